// File: rtl/lsu_order_violation_searcher.sv
// Memory-ordering checker: registers committing stores, searches the LDQ for younger
// succeeded loads that overlap them, and reports the oldest failing load to the ROB.
module lsu_order_violation_searcher #(
   parameter int XLEN          = 32,
   parameter int LDQ_SIZE      = 32,
   parameter int STQ_SIZE      = 32,
   parameter int N_STORE_PORTS = 2
) (
   input  logic                                    clk,
   input  logic                                    reset_n,
   input  logic                                    kill,
   input  logic [LDQ_SIZE-1:0]                     ldq_valid,
   input  logic [LDQ_SIZE*XLEN-1:0]                ldq_address,
   input  logic [LDQ_SIZE*(XLEN/8)-1:0]            ldq_byte_mask,
   input  logic [LDQ_SIZE-1:0]                     ldq_succeeded,
   input  logic [LDQ_SIZE*STQ_SIZE-1:0]            ldq_store_mask,
   input  logic [LDQ_SIZE-1:0]                     ldq_forwarded,
   input  logic [LDQ_SIZE*$clog2(STQ_SIZE)-1:0]    ldq_forward_stq_index,
   input  logic [$clog2(LDQ_SIZE)-1:0]             ldq_head,
   input  logic [$clog2(STQ_SIZE)-1:0]             stq_head,
   input  logic [STQ_SIZE*XLEN-1:0]                stq_address,
   input  logic [STQ_SIZE*(XLEN/8)-1:0]            stq_byte_mask,
   input  logic [N_STORE_PORTS-1:0]                store_fired,
   input  logic [N_STORE_PORTS*$clog2(STQ_SIZE)-1:0] store_fired_index,
   output logic [LDQ_SIZE-1:0]                     order_failures,
   output logic                                    flush_valid,
   input  logic                                    flush_ready,
   output logic [$clog2(LDQ_SIZE)-1:0]             flush_ldq_index
);

   localparam int BW = XLEN / 8;
   localparam int LW = $clog2(LDQ_SIZE);
   localparam int SW = $clog2(STQ_SIZE);
   localparam int AW = XLEN - 2;

   typedef enum logic [0:0] {
      ST_IDLE   = 1'b0,
      ST_REPORT = 1'b1
   } state_e;

   logic [N_STORE_PORTS-1:0] s1_valid_q, s1_valid_d;
   logic [SW-1:0]            s1_idx_q  [N_STORE_PORTS];
   logic [SW-1:0]            s1_idx_d  [N_STORE_PORTS];
   logic [AW-1:0]            s1_addr_q [N_STORE_PORTS];
   logic [AW-1:0]            s1_addr_d [N_STORE_PORTS];
   logic [BW-1:0]            s1_bm_q   [N_STORE_PORTS];
   logic [BW-1:0]            s1_bm_d   [N_STORE_PORTS];
   logic [SW-1:0]            s1_head_q [N_STORE_PORTS];
   logic [SW-1:0]            s1_head_d [N_STORE_PORTS];

   logic [LDQ_SIZE-1:0]      pend_q, pend_d;
   logic [LDQ_SIZE-1:0]      hit_s, clr_s;
   state_e                   state_q, state_d;
   logic                     flush_valid_q, flush_valid_d;
   logic [LW-1:0]            flush_idx_q, flush_idx_d;

   logic [SW-1:0]            fwd_idx_s, fwd_age_s, st_age_s;
   logic                     addr_eq_s, bm_ov_s, fwd_ok_s;
   logic                     handshake_s;
   logic [LW-1:0]            rep_age_s, age_s, probe_s, oldest_idx_s;
   logic                     oldest_found_s;
   logic                     unused_addr_lsbs_s;

   assign order_failures  = pend_q;
   assign flush_valid     = flush_valid_q;
   assign flush_ldq_index = flush_idx_q;
   assign handshake_s     = flush_valid_q & flush_ready;

   // Stage-1 capture of each firing store's index, word address, byte mask and STQ head
   always_comb begin
      for (int p = 0; p < N_STORE_PORTS; p++) begin
         s1_idx_d[p]  = s1_idx_q[p];
         s1_addr_d[p] = s1_addr_q[p];
         s1_bm_d[p]   = s1_bm_q[p];
         s1_head_d[p] = s1_head_q[p];
         if (kill) begin
            s1_valid_d[p] = 1'b0;
         end else begin
            s1_valid_d[p] = store_fired[p];
         end
         if (store_fired[p]) begin
            s1_idx_d[p]  = store_fired_index[p*SW +: SW];
            s1_addr_d[p] = stq_address[int'(store_fired_index[p*SW +: SW])*XLEN + 2 +: AW];
            s1_bm_d[p]   = stq_byte_mask[int'(store_fired_index[p*SW +: SW])*BW +: BW];
            s1_head_d[p] = stq_head;
         end else begin
            s1_idx_d[p]  = s1_idx_q[p];
         end
      end
   end

   // Search every LDQ entry against every registered store and OR the hits together
   always_comb begin
      hit_s     = '0;
      fwd_idx_s = '0;
      fwd_age_s = '0;
      st_age_s  = '0;
      addr_eq_s = 1'b0;
      bm_ov_s   = 1'b0;
      fwd_ok_s  = 1'b0;
      for (int p = 0; p < N_STORE_PORTS; p++) begin
         for (int i = 0; i < LDQ_SIZE; i++) begin
            fwd_idx_s = ldq_forward_stq_index[i*SW +: SW];
            fwd_age_s = fwd_idx_s - s1_head_q[p];
            st_age_s  = s1_idx_q[p] - s1_head_q[p];
            addr_eq_s = (ldq_address[i*XLEN + 2 +: AW] == s1_addr_q[p]);
            bm_ov_s   = |(ldq_byte_mask[i*BW +: BW] & s1_bm_q[p]);
            // forwarding from the store itself or a younger one saw the right data
            fwd_ok_s  = ~ldq_forwarded[i] | (fwd_age_s < st_age_s);
            if (s1_valid_q[p] && ldq_valid[i] && ldq_succeeded[i]
                && ldq_store_mask[i*STQ_SIZE + int'(s1_idx_q[p])]
                && addr_eq_s && bm_ov_s && fwd_ok_s) begin
               hit_s[i] = 1'b1;
            end else begin
               hit_s[i] = hit_s[i];
            end
         end
      end
   end

   // Sticky pending vector: handshake clears the reported load and everything younger
   always_comb begin
      rep_age_s = flush_idx_q - ldq_head;
      age_s     = '0;
      clr_s     = '0;
      for (int i = 0; i < LDQ_SIZE; i++) begin
         age_s    = LW'(i) - ldq_head;
         clr_s[i] = handshake_s & (age_s >= rep_age_s);
      end
      if (kill) begin
         pend_d = '0;
      end else begin
         pend_d = (pend_q | hit_s) & ldq_valid & ~clr_s;
      end
   end

   // Oldest pending load, scanning from ldq_head in age order
   always_comb begin
      oldest_found_s = 1'b0;
      oldest_idx_s   = '0;
      probe_s        = '0;
      for (int k = 0; k < LDQ_SIZE; k++) begin
         probe_s = ldq_head + LW'(k);
         if (!oldest_found_s && pend_d[probe_s]) begin
            oldest_found_s = 1'b1;
            oldest_idx_s   = probe_s;
         end else begin
            oldest_found_s = oldest_found_s;
         end
      end
   end

   // Report FSM next state; the reported index only moves on entry or on a handshake
   always_comb begin
      state_d       = state_q;
      flush_valid_d = flush_valid_q;
      flush_idx_d   = flush_idx_q;
      if (kill) begin
         state_d       = ST_IDLE;
         flush_valid_d = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (oldest_found_s) begin
                  state_d       = ST_REPORT;
                  flush_valid_d = 1'b1;
                  flush_idx_d   = oldest_idx_s;
               end else begin
                  flush_valid_d = 1'b0;
               end
            end
            ST_REPORT: begin
               if (handshake_s && oldest_found_s) begin
                  flush_idx_d = oldest_idx_s;
               end else if (handshake_s) begin
                  state_d       = ST_IDLE;
                  flush_valid_d = 1'b0;
               end else begin
                  flush_valid_d = 1'b1;
               end
            end
            default: begin
               state_d       = ST_IDLE;
               flush_valid_d = 1'b0;
            end
         endcase
      end
   end

   // Byte-offset address bits do not take part in the word comparison
   always_comb begin
      unused_addr_lsbs_s = 1'b0;
      for (int i = 0; i < LDQ_SIZE; i++) begin
         unused_addr_lsbs_s = unused_addr_lsbs_s ^ (^ldq_address[i*XLEN +: 2]);
      end
      for (int j = 0; j < STQ_SIZE; j++) begin
         unused_addr_lsbs_s = unused_addr_lsbs_s ^ (^stq_address[j*XLEN +: 2]);
      end
   end

   // Stage-1 store registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s1_valid_q <= '0;
         for (int p = 0; p < N_STORE_PORTS; p++) begin
            s1_idx_q[p]  <= '0;
            s1_addr_q[p] <= '0;
            s1_bm_q[p]   <= '0;
            s1_head_q[p] <= '0;
         end
      end else begin
         s1_valid_q <= s1_valid_d;
         for (int p = 0; p < N_STORE_PORTS; p++) begin
            s1_idx_q[p]  <= s1_idx_d[p];
            s1_addr_q[p] <= s1_addr_d[p];
            s1_bm_q[p]   <= s1_bm_d[p];
            s1_head_q[p] <= s1_head_d[p];
         end
      end
   end

   // Pending vector and report FSM registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pend_q        <= '0;
         state_q       <= ST_IDLE;
         flush_valid_q <= 1'b0;
         flush_idx_q   <= '0;
      end else begin
         pend_q        <= pend_d;
         state_q       <= state_d;
         flush_valid_q <= flush_valid_d;
         flush_idx_q   <= flush_idx_d;
      end
   end

endmodule

// File: tb/tb_lsu_order_violation_searcher.sv
// Bench for lsu_order_violation_searcher: directed vector table, hand-written corner
// sequences and random traffic against an age-arithmetic reference model.
module tb_lsu_order_violation_searcher;

   localparam int XLEN = 32;
   localparam int LDQ  = 32;
   localparam int STQ  = 32;
   localparam int NP   = 2;
   localparam int BW   = 4;
   localparam int LW   = 5;
   localparam int SW   = 5;

   logic                 clk, reset_n, kill, flush_ready;
   logic [LDQ-1:0]       ldq_valid, ldq_succeeded, ldq_forwarded;
   logic [LDQ*XLEN-1:0]  ldq_address;
   logic [LDQ*BW-1:0]    ldq_byte_mask;
   logic [LDQ*STQ-1:0]   ldq_store_mask;
   logic [LDQ*SW-1:0]    ldq_forward_stq_index;
   logic [LW-1:0]        ldq_head;
   logic [SW-1:0]        stq_head;
   logic [STQ*XLEN-1:0]  stq_address;
   logic [STQ*BW-1:0]    stq_byte_mask;
   logic [NP-1:0]        store_fired;
   logic [NP*SW-1:0]     store_fired_index;
   logic [LDQ-1:0]       order_failures;
   logic                 flush_valid;
   logic [LW-1:0]        flush_ldq_index;

   lsu_order_violation_searcher #(
      .XLEN(XLEN), .LDQ_SIZE(LDQ), .STQ_SIZE(STQ), .N_STORE_PORTS(NP)
   ) dut (
      .clk(clk), .reset_n(reset_n), .kill(kill),
      .ldq_valid(ldq_valid), .ldq_address(ldq_address), .ldq_byte_mask(ldq_byte_mask),
      .ldq_succeeded(ldq_succeeded), .ldq_store_mask(ldq_store_mask),
      .ldq_forwarded(ldq_forwarded), .ldq_forward_stq_index(ldq_forward_stq_index),
      .ldq_head(ldq_head), .stq_head(stq_head), .stq_address(stq_address),
      .stq_byte_mask(stq_byte_mask), .store_fired(store_fired),
      .store_fired_index(store_fired_index), .order_failures(order_failures),
      .flush_valid(flush_valid), .flush_ready(flush_ready),
      .flush_ldq_index(flush_ldq_index)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference model state
   logic [LDQ-1:0]  m_pend;
   logic            m_fv;
   int              m_fidx;
   logic            ms_valid [NP];
   int              ms_idx   [NP];
   logic [XLEN-1:0] ms_addr  [NP];
   logic [BW-1:0]   ms_bm    [NP];
   int              ms_head  [NP];

   int vectors;
   int miscompares;

   typedef struct {
      logic [31:0] ld_addr;
      logic [3:0]  ld_bm;
      logic        succ;
      logic        smask;
      logic        fwd;
      int          fidx;
      int          sthead;
      logic [31:0] st_addr;
      logic [3:0]  st_bm;
      logic        exp_fail;
   } vec_t;

   vec_t tbl [10];

   function automatic int md(input int v);
      return ((v % 32) + 32) % 32;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_pend = '0;
      m_fv   = 1'b0;
      m_fidx = 0;
      for (int p = 0; p < NP; p++) ms_valid[p] = 1'b0;
   endtask

   // One clock edge of the reference, computed from the inputs currently applied
   task automatic model_step();
      logic [LDQ-1:0] hit, nxt;
      logic           hs, ok;
      int             rep_age, best, best_age, fwd_i, head;
      hit  = '0;
      head = int'(ldq_head);
      for (int p = 0; p < NP; p++) begin
         if (ms_valid[p]) begin
            for (int i = 0; i < LDQ; i++) begin
               fwd_i = int'(ldq_forward_stq_index[i*SW +: SW]);
               ok = ldq_valid[i] && ldq_succeeded[i] && ldq_store_mask[i*STQ + ms_idx[p]]
                    && ((ldq_address[i*XLEN +: XLEN] >> 2) == (ms_addr[p] >> 2))
                    && ((ldq_byte_mask[i*BW +: BW] & ms_bm[p]) != 4'h0)
                    && (!ldq_forwarded[i] ||
                        md(fwd_i - ms_head[p]) < md(ms_idx[p] - ms_head[p]));
               if (ok) hit[i] = 1'b1;
            end
         end
      end
      hs      = m_fv && flush_ready;
      rep_age = md(m_fidx - head);
      nxt     = m_pend | hit;
      for (int i = 0; i < LDQ; i++) begin
         if (!ldq_valid[i] || (hs && md(i - head) >= rep_age)) nxt[i] = 1'b0;
      end
      if (kill) nxt = '0;
      best     = -1;
      best_age = LDQ;
      for (int i = 0; i < LDQ; i++) begin
         if (nxt[i] && md(i - head) < best_age) begin
            best     = i;
            best_age = md(i - head);
         end
      end
      if (kill) begin
         m_fv = 1'b0;
      end else if (!m_fv) begin
         if (best >= 0) begin
            m_fv   = 1'b1;
            m_fidx = best;
         end
      end else if (hs) begin
         if (best >= 0) m_fidx = best;
         else m_fv = 1'b0;
      end
      m_pend = nxt;
      for (int p = 0; p < NP; p++) begin
         if (kill) begin
            ms_valid[p] = 1'b0;
         end else begin
            ms_valid[p] = store_fired[p];
            if (store_fired[p]) begin
               ms_idx[p]  = int'(store_fired_index[p*SW +: SW]);
               ms_addr[p] = stq_address[ms_idx[p]*XLEN +: XLEN];
               ms_bm[p]   = stq_byte_mask[ms_idx[p]*BW +: BW];
               ms_head[p] = int'(stq_head);
            end
         end
      end
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
      check("order_failures", order_failures, m_pend);
      check("flush_valid", 32'(flush_valid), 32'(m_fv));
      if (m_fv) check("flush_ldq_index", 32'(flush_ldq_index), 32'(m_fidx));
   endtask

   task automatic set_load(input int i, input logic [31:0] a, input logic [3:0] bm,
                           input logic succ, input logic [31:0] smask,
                           input logic fwd, input int fidx);
      ldq_valid[i]                      = 1'b1;
      ldq_address[i*XLEN +: XLEN]       = a;
      ldq_byte_mask[i*BW +: BW]         = bm;
      ldq_succeeded[i]                  = succ;
      ldq_store_mask[i*STQ +: STQ]      = smask;
      ldq_forwarded[i]                  = fwd;
      ldq_forward_stq_index[i*SW +: SW] = 5'(fidx);
   endtask

   task automatic set_store(input int j, input logic [31:0] a, input logic [3:0] bm);
      stq_address[j*XLEN +: XLEN] = a;
      stq_byte_mask[j*BW +: BW]   = bm;
   endtask

   task automatic fire(input int p, input int idx);
      store_fired[p]                = 1'b1;
      store_fired_index[p*SW +: SW] = 5'(idx);
   endtask

   task automatic zero_inputs();
      ldq_valid = '0; ldq_succeeded = '0; ldq_forwarded = '0;
      ldq_address = '0; ldq_byte_mask = '0; ldq_store_mask = '0;
      ldq_forward_stq_index = '0; ldq_head = '0; stq_head = '0;
      stq_address = '0; stq_byte_mask = '0; store_fired = '0;
      store_fired_index = '0; flush_ready = 1'b0;
   endtask

   task automatic clear_all();
      zero_inputs();
      kill = 1'b1;
      tick();
      kill = 1'b0;
   endtask

   task automatic rand_load(input int j);
      if ($urandom % 8 == 0) begin
         ldq_valid[j] = 1'b0;
      end else begin
         set_load(j, 32'h100 + 32'(4 * $urandom_range(0, 3)) + 32'($urandom_range(0, 3)),
                  4'($urandom), ($urandom % 4) != 0, $urandom, ($urandom % 3) == 0,
                  int'($urandom % 32));
      end
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      kill        = 1'b0;
      reset_n     = 1'b0;
      zero_inputs();
      model_reset();
      #1;
      check("reset_failures", order_failures, 32'h0);
      check("reset_flush_valid", 32'(flush_valid), 32'h0);
      check("reset_flush_index", 32'(flush_ldq_index), 32'h0);
      @(posedge clk); #1;
      reset_n = 1'b1;

      // ld_addr, ld_bm, succ, smask, fwd, fidx, sthead, st_addr, st_bm, exp_fail
      tbl[0] = '{32'h100, 4'h1, 1'b1, 1'b1, 1'b0, 0, 0, 32'h100, 4'hF, 1'b1};
      tbl[1] = '{32'h100, 4'h1, 1'b1, 1'b1, 1'b1, 3, 0, 32'h100, 4'hF, 1'b0};
      tbl[2] = '{32'h100, 4'h1, 1'b1, 1'b1, 1'b1, 1, 0, 32'h100, 4'hF, 1'b1};
      tbl[3] = '{32'h100, 4'h1, 1'b1, 1'b1, 1'b1, 1, 4, 32'h100, 4'hF, 1'b1};
      tbl[4] = '{32'h100, 4'h1, 1'b1, 1'b1, 1'b1, 1, 2, 32'h100, 4'hF, 1'b0};
      tbl[5] = '{32'h100, 4'h3, 1'b1, 1'b1, 1'b0, 0, 0, 32'h100, 4'hC, 1'b0};
      tbl[6] = '{32'h104, 4'h1, 1'b1, 1'b1, 1'b0, 0, 0, 32'h100, 4'hF, 1'b0};
      tbl[7] = '{32'h102, 4'h1, 1'b1, 1'b1, 1'b0, 0, 0, 32'h100, 4'hF, 1'b1};
      tbl[8] = '{32'h100, 4'h1, 1'b0, 1'b1, 1'b0, 0, 0, 32'h100, 4'hF, 1'b0};
      tbl[9] = '{32'h100, 4'h1, 1'b1, 1'b0, 1'b0, 0, 0, 32'h100, 4'hF, 1'b0};

      for (int v = 0; v < 10; v++) begin
         clear_all();
         stq_head = 5'(tbl[v].sthead);
         set_store(3, tbl[v].st_addr, tbl[v].st_bm);
         set_load(5, tbl[v].ld_addr, tbl[v].ld_bm, tbl[v].succ,
                  tbl[v].smask ? 32'h8 : 32'h0, tbl[v].fwd, tbl[v].fidx);
         fire(0, 3);
         tick();
         store_fired = '0;
         check("latency_t1_flush_valid", 32'(flush_valid), 32'h0);
         tick();
         check("table_fail_bit", 32'(order_failures[5]), 32'(tbl[v].exp_fail));
         check("table_flush_valid", 32'(flush_valid), 32'(tbl[v].exp_fail));
         if (tbl[v].exp_fail) check("table_flush_index", 32'(flush_ldq_index), 32'd5);
      end

      // Dual port: loads 7 and 9 fail, head 8 makes 9 the oldest
      clear_all();
      ldq_head = 5'd8;
      set_store(2, 32'h200, 4'hF);
      set_store(6, 32'h300, 4'hF);
      set_load(7, 32'h200, 4'h1, 1'b1, 32'h4, 1'b0, 0);
      set_load(9, 32'h300, 4'h1, 1'b1, 32'h40, 1'b0, 0);
      fire(0, 2);
      fire(1, 6);
      tick();
      store_fired = '0;
      tick();
      check("dual_failures", order_failures, 32'h280);
      check("dual_index_first", 32'(flush_ldq_index), 32'd9);
      for (int c = 0; c < 3; c++) begin
         tick();
         check("dual_index_held", 32'(flush_ldq_index), 32'd9);
      end
      flush_ready = 1'b1;
      tick();
      flush_ready = 1'b0;
      check("dual_cleared", order_failures, 32'h0);
      check("dual_idle", 32'(flush_valid), 32'h0);

      // A hit on an older load in the handshake cycle survives and is reported next
      clear_all();
      set_store(3, 32'h100, 4'hF);
      set_store(4, 32'h400, 4'hF);
      set_load(10, 32'h100, 4'h1, 1'b1, 32'h8, 1'b0, 0);
      set_load(4, 32'h400, 4'h1, 1'b1, 32'h10, 1'b0, 0);
      fire(0, 3);
      tick();
      store_fired = '0;
      tick();
      check("older_first_index", 32'(flush_ldq_index), 32'd10);
      fire(0, 4);
      tick();
      store_fired = '0;
      flush_ready = 1'b1;
      tick();
      flush_ready = 1'b0;
      check("older_survives", order_failures, 32'h10);
      check("older_reloaded", 32'(flush_ldq_index), 32'd4);

      // kill during the S1 cycle drops the store
      clear_all();
      set_store(3, 32'h100, 4'hF);
      set_load(5, 32'h100, 4'h1, 1'b1, 32'h8, 1'b0, 0);
      fire(0, 3);
      tick();
      store_fired = '0;
      kill = 1'b1;
      tick();
      kill = 1'b0;
      tick();
      check("kill_no_pending", order_failures, 32'h0);
      check("kill_no_flush", 32'(flush_valid), 32'h0);

      // Asynchronous reset while reporting
      fire(0, 3);
      tick();
      store_fired = '0;
      tick();
      check("pre_reset_flush_valid", 32'(flush_valid), 32'h1);
      #3;
      reset_n = 1'b0;
      #1;
      check("async_reset_flush_valid", 32'(flush_valid), 32'h0);
      check("async_reset_failures", order_failures, 32'h0);
      model_reset();
      @(posedge clk); #1;
      reset_n = 1'b1;

      // Random traffic against the reference
      clear_all();
      for (int j = 0; j < LDQ; j++) rand_load(j);
      for (int j = 0; j < STQ; j++)
         set_store(j, 32'h100 + 32'(4 * $urandom_range(0, 3)), 4'($urandom_range(1, 15)));
      for (int c = 0; c < 2000; c++) begin
         if ($urandom % 4 == 0) rand_load(int'($urandom % 32));
         if ($urandom % 4 == 0)
            set_store(int'($urandom % 32), 32'h100 + 32'(4 * $urandom_range(0, 3)),
                      4'($urandom_range(1, 15)));
         if ($urandom % 16 == 0) ldq_head = 5'($urandom);
         if ($urandom % 16 == 0) stq_head = 5'($urandom);
         store_fired       = 2'($urandom);
         store_fired_index = 10'($urandom);
         flush_ready       = 1'($urandom);
         kill              = ($urandom % 64) == 0;
         tick();
      end
      kill        = 1'b0;
      store_fired = '0;

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
